id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage directly upstream of the ALU in the 5-stage MIPS pipeline.
- Latches decoded operands and control from ID.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and detects load-use hazards (stall request plus bubble).
- Drives the ALU's two 32-bit operands and 4-bit op code, plus the control passed on to the EX/MEM register.

Parameters:
DATA_W, 32, datapath width; must equal ALU operand width
REG_AW, 5, register-index width; index 0 is hardwired zero

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs, id_rt, id_rd  in  REG_AW each  source/dest indices (id_rd = final write index)
id_rs_val, id_rt_val  in  DATA_W each  register-file read data
id_imm  in  DATA_W  extended immediate
id_shamt  in  5  shift amount field
id_alu_op  in  4  ALU code (0000 add, 0010 sub, 0100 and, 0101 or, 0110 nor, 0111 xor, 1000 shl, 1010 shr, 1001 sra)
id_a_sel  in  1  0: A=rs, 1: A=rt (shifts)
id_b_sel  in  2  00 rt, 01 imm, 10 zero-extended shamt, 11 rs (variable shifts)
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control
flush  in  1  branch/jump redirect: kill instruction entering EX
exmem_reg_write  in  1  EX/MEM writes a register
exmem_rd  in  REG_AW  EX/MEM destination
exmem_result  in  DATA_W  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB writes a register
memwb_rd  in  REG_AW  MEM/WB destination
memwb_result  in  DATA_W  MEM/WB writeback value
stall_id  out  1  load-use stall: PC and IF/ID must hold
ex_valid  out  1  EX holds a real instruction
alu_in_a, alu_in_b  out  DATA_W each  ALU operands
alu_op  out  4  ALU code
ex_store_data  out  DATA_W  forwarded rt value for stores
ex_rd  out  REG_AW  destination
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  gated control

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset clears all EX registers to 0. Resulting outputs:
  - ex_valid=0, alu_op=0000, ex_rd=0, all control=0.
  - alu_in_a/b=0 while no forwarding match is active.
  - stall_id=0.
- Registered fields: valid, rs, rt, rd, rs_val, rt_val, imm, shamt, alu_op, a_sel, b_sel, control.
- Load-use detect, combinational:
  - stall_id=1 iff id_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt).
  - Both rs and rt are compared regardless of use. This is conservative but acceptable.
- Per-edge update, highest priority first:
  1. rst.
  2. flush or stall_id: load a bubble (valid=0, all control=0, alu_op=0000, rd=0).
  3. Otherwise capture ID fields; control is gated by id_valid, so an invalid instruction becomes a bubble.
- Forwarding, combinational on the registered rs/rt, evaluated independently for each source:
  - If exmem_reg_write & exmem_rd!=0 & exmem_rd==src, use exmem_result.
  - Else if memwb_reg_write & memwb_rd!=0 & memwb_rd==src, use memwb_result.
  - Else use the registered value.
  - EX/MEM has priority over MEM/WB. Source index 0 never forwards.
- Operand select:
  - alu_in_a = a_sel ? fwd_rt : fwd_rs.
  - alu_in_b per b_sel: fwd_rt / imm / {zeros,shamt} / fwd_rs.
- ex_store_data = fwd_rt.
- Latency: ID fields appear at the ALU one cycle after capture. Forwarded values are same-cycle.
- Stall lasts exactly 1 cycle per load-use, because the load leaves EX on the next edge.
- flush and stall in the same cycle: single bubble. stall_id still reflects the combinational condition; the hazard unit upstream gives flush priority.
- Reset asserted mid-stall: outputs go to reset values immediately, without waiting for clk.

Test Plan:
1. Reset: assert rst between edges -> all outputs 0 immediately; release, present id add r3=r1+r2 (r1=5, r2=7, b_sel=00) -> next cycle alu_in_a=5, alu_in_b=7, alu_op=0000, ex_rd=3, ex_reg_write=1.
2. Forward priority: EX holds rs=4; exmem_rd=4 (0xAAAA), memwb_rd=4 (0xBBBB) both writing -> alu_in_a=0xAAAA; drop exmem_reg_write -> 0xBBBB; set rs=0 with both rd=0 -> registered value, no forward.
3. Load-use: EX holds lw to r8 (mem_read=1); ID presents add r9=r8+r1 -> stall_id=1 that cycle; next edge EX becomes bubble (ex_valid=0, ex_reg_write=0); stall_id then 0; ID instruction captured on following edge.
4. Shift mux: sll r5,r6,3 (a_sel=1, b_sel=10, alu_op=1000, r6=0x1) -> alu_in_a=0x1, alu_in_b=3; srav (b_sel=11, rs=2 holding 4, rt=0x80000000) -> alu_in_a=0x80000000, alu_in_b=4, alu_op=1001.
5. Flush: flush=1 with valid sw in ID -> EX bubble, ex_mem_write=0; flush with stall_id=1 -> single bubble, no lost capture after release.
6. Store forwarding: sw rt=7, exmem_rd=7 result 0x1234 -> ex_store_data=0x1234, alu_in_b=imm when b_sel=01.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use detection.
// Feeds the ALU operands/op code and the control carried into EX/MEM.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_val,
    input  logic [DATA_W-1:0] id_rt_val,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [3:0]        id_alu_op,
    input  logic              id_a_sel,
    input  logic [1:0]        id_b_sel,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [DATA_W-1:0] alu_in_a,
    output logic [DATA_W-1:0] alu_in_b,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg
);

    // Valid semantics: valid_q marks a real instruction in EX; a bubble has
    // valid_q=0 and every control bit 0, so it can never write state downstream.
    logic              valid_q,      valid_d;
    logic [REG_AW-1:0] rs_q,         rs_d;
    logic [REG_AW-1:0] rt_q,         rt_d;
    logic [REG_AW-1:0] rd_q,         rd_d;
    logic [DATA_W-1:0] rs_val_q,     rs_val_d;
    logic [DATA_W-1:0] rt_val_q,     rt_val_d;
    logic [DATA_W-1:0] imm_q,        imm_d;
    logic [4:0]        shamt_q,      shamt_d;
    logic [3:0]        alu_op_q,     alu_op_d;
    logic              a_sel_q,      a_sel_d;
    logic [1:0]        b_sel_q,      b_sel_d;
    logic              reg_write_q,  reg_write_d;
    logic              mem_read_q,   mem_read_d;
    logic              mem_write_q,  mem_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // Both sources are compared even when the instruction ignores one of them.
    assign stall_id = id_valid & valid_q & mem_read_q & (rd_q != '0) &
                      ((rd_q == id_rs) | (rd_q == id_rt));

    always_comb begin
        valid_d      = id_valid;
        rs_d         = id_rs;
        rt_d         = id_rt;
        rd_d         = id_rd;
        rs_val_d     = id_rs_val;
        rt_val_d     = id_rt_val;
        imm_d        = id_imm;
        shamt_d      = id_shamt;
        alu_op_d     = id_alu_op;
        a_sel_d      = id_a_sel;
        b_sel_d      = id_b_sel;
        reg_write_d  = id_reg_write  & id_valid;
        mem_read_d   = id_mem_read   & id_valid;
        mem_write_d  = id_mem_write  & id_valid;
        mem_to_reg_d = id_mem_to_reg & id_valid;
        if (flush | stall_id) begin
            valid_d      = 1'b0;
            rs_d         = '0;
            rt_d         = '0;
            rd_d         = '0;
            rs_val_d     = '0;
            rt_val_d     = '0;
            imm_d        = '0;
            shamt_d      = '0;
            alu_op_d     = '0;
            a_sel_d      = 1'b0;
            b_sel_d      = '0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            rs_val_q     <= '0;
            rt_val_q     <= '0;
            imm_q        <= '0;
            shamt_q      <= '0;
            alu_op_q     <= '0;
            a_sel_q      <= 1'b0;
            b_sel_q      <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            rs_val_q     <= rs_val_d;
            rt_val_q     <= rt_val_d;
            imm_q        <= imm_d;
            shamt_q      <= shamt_d;
            alu_op_q     <= alu_op_d;
            a_sel_q      <= a_sel_d;
            b_sel_q      <= b_sel_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    // EX/MEM is the younger producer, so it wins over MEM/WB; r0 never forwards.
    always_comb begin
        fwd_rs = rs_val_q;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs_q)
            fwd_rs = exmem_result;
        else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs_q)
            fwd_rs = memwb_result;
    end

    always_comb begin
        fwd_rt = rt_val_q;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rt_q)
            fwd_rt = exmem_result;
        else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rt_q)
            fwd_rt = memwb_result;
    end

    always_comb begin
        alu_in_a = a_sel_q ? fwd_rt : fwd_rs;
        case (b_sel_q)
            2'b00:   alu_in_b = fwd_rt;
            2'b01:   alu_in_b = imm_q;
            2'b10:   alu_in_b = {{(DATA_W-5){1'b0}}, shamt_q};
            default: alu_in_b = fwd_rs;
        endcase
    end

    assign ex_valid      = valid_q;
    assign alu_op        = alu_op_q;
    assign ex_store_data = fwd_rt;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_mem_to_reg = mem_to_reg_q;

endmodule
